uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_PULSE, default 4: clk cycles per serial bit period.
REQ-002 SHALL have parameter BITS_PER_WORD, default 8: data bits per serial frame.
REQ-003 SHALL have parameter W_IN, default 24: width of the parallel input word; integer multiple of BITS_PER_WORD.
REQ-004 SHALL have port clk  input  1  clock, rising-edge active.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_valid  input  1  upstream word valid.
REQ-007 SHALL have port s_data  input  W_IN  upstream word.
REQ-008 SHALL have port s_ready  output  1  block can accept a word.
REQ-009 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-010 SHALL define NUM_WORDS = W_IN/BITS_PER_WORD; each accepted word is sent as NUM_WORDS consecutive frames.
REQ-011 SHALL run an FSM with states IDLE, START, DATA, END (plus PARITY, see REQ-027); all outputs registered.
REQ-012 SHALL accept a word on any rising edge with s_valid=1 and s_ready=1: latch s_data into a W_IN shift register, deassert s_ready, go IDLE->START.
REQ-013 SHALL assert s_ready only in IDLE; s_valid while s_ready=0 is ignored, and s_data is not sampled.
REQ-014 SHALL drive tx=0 for exactly CLOCKS_PER_PULSE cycles in START, starting the cycle after acceptance (latency 1 cycle).
REQ-015 SHALL in DATA drive tx = shift register bit 0 for CLOCKS_PER_PULSE cycles per bit, then shift right by one; BITS_PER_WORD bits per frame.
REQ-016 SHALL transmit frames in order s_data[BITS_PER_WORD-1:0] first, ascending, each frame LSB first.
REQ-017 SHALL drive tx=1 for CLOCKS_PER_PULSE cycles in END (one stop bit).
REQ-018 SHALL after END go to START if frames remain, else to IDLE with s_ready=1 on the next cycle.
REQ-019 SHALL give a full word duration of NUM_WORDS*(BITS_PER_WORD+2)*CLOCKS_PER_PULSE cycles (parity off), tx fall to final stop-bit end.
REQ-020 SHALL size counters c_clocks, c_bits, c_words to $clog2 of their limits, each wrapping to 0 at limit-1.
REQ-021 SHALL re-accept a waiting word in the first IDLE cycle, so back-to-back words have one idle-high cycle between the last stop bit and the next start bit.
REQ-022 SHALL keep tx=1 continuously while in IDLE.

Reset
REQ-023 SHALL on rstn=0, asynchronously: state=IDLE, tx=1, s_ready=0, all counters and shift register 0.
REQ-024 SHALL assert s_ready=1 on the first rising edge after rstn deasserts.
REQ-025 SHALL on reset mid-frame abandon the word, with tx=1 immediately and no resumption.

Configuration
REQ-026 SHALL use macro UART_TX_PARITY_EN to compile the parity feature in or out.
REQ-027 SHALL with UART_TX_PARITY_EN defined insert a PARITY state between DATA and END, driving the even-parity bit (XOR of the frame's data bits) for CLOCKS_PER_PULSE cycles; frame duration becomes (BITS_PER_WORD+3)*CLOCKS_PER_PULSE.
REQ-028 SHALL without UART_TX_PARITY_EN contain no PARITY state or parity logic, with DATA going directly to END.

Verification
REQ-029 SHALL cover the basic frame: defaults, s_data=0x5AC30F with one-cycle s_valid -> tx = 0,1111 0000,1 | 0,1100 0011,1 | 0,0101 1010,1, each bit 4 cycles, 120 cycles total, s_ready low throughout.
REQ-030 SHALL cover back-to-back words: s_valid held high with 0x000001 then 0xFFFFFF -> second accepted exactly 1 cycle after the first word's final stop bit, and both sent correctly.
REQ-031 SHALL cover ignored input: s_valid pulses with 0x123456 during a transfer -> no effect, and the original word is sent unchanged.
REQ-032 SHALL cover reset mid-operation: rstn low in DATA of frame 2 -> tx=1 and s_ready=0 immediately, s_ready=1 one edge after release, and the next word is sent from frame 0.
REQ-033 SHALL cover parity: with UART_TX_PARITY_EN and s_data=0x07030F -> parity bits 0,0,1, 132 cycles total.
REQ-034 SHALL cover loopback: tx connected to the team's UART receiver (same parameters), 100 random words -> each received m_data equals the sent s_data, with one m_valid pulse per word.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: serialises a W_IN-bit parallel word as W_IN/BITS_PER_WORD
// consecutive UART frames (start bit, data LSB first, stop bit), low frame first.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit after the data bits.
// Reset is asynchronous and active-low; tx is driven high while idle or in reset.
module uart_tx #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_IN             = 24
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_valid,
    input  logic [W_IN-1:0] s_data,
    output logic            s_ready,
    output logic            tx
);

    localparam int NUM_WORDS = W_IN / BITS_PER_WORD;

    // Counter widths; a limit of 1 still needs a one-bit counter.
    localparam int CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BW = (BITS_PER_WORD > 1)    ? $clog2(BITS_PER_WORD)    : 1;
    localparam int WW = (NUM_WORDS > 1)        ? $clog2(NUM_WORDS)        : 1;

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_WORD - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, END, PARITY} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, END} state_t;
`endif

    state_t          state_q,    state_d;
    logic            tx_q,       tx_d;
    logic            s_ready_q,  s_ready_d;
    logic [CW-1:0]   c_clocks_q, c_clocks_d;
    logic [BW-1:0]   c_bits_q,   c_bits_d;
    logic [WW-1:0]   c_words_q,  c_words_d;
    logic [W_IN-1:0] shift_q,    shift_d;
`ifdef UART_TX_PARITY_EN
    logic            parity_q,   parity_d;
`endif

    logic bit_end;
    assign bit_end = (c_clocks_q == CLK_LAST);

    // Next-state logic: every output is computed one cycle ahead so tx and
    // s_ready come straight from flops.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        s_ready_d  = s_ready_q;
        c_clocks_d = c_clocks_q;
        c_bits_d   = c_bits_q;
        c_words_d  = c_words_q;
        shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (s_ready_q && s_valid) begin
                    shift_d   = s_data;
                    s_ready_d = 1'b0;
                    state_d   = START;
                    tx_d      = 1'b0;
                end else begin
                    s_ready_d = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    c_clocks_d = '0;
                    state_d    = DATA;
                    tx_d       = shift_q[0];
`ifdef UART_TX_PARITY_EN
                    parity_d   = 1'b0;
`endif
                end else begin
                    c_clocks_d = c_clocks_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    c_clocks_d = '0;
                    shift_d    = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
                    parity_d   = parity_q ^ shift_q[0];
`endif
                    if (c_bits_q == BIT_LAST) begin
                        c_bits_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = PARITY;
                        tx_d     = parity_q ^ shift_q[0];
`else
                        state_d  = END;
                        tx_d     = 1'b1;
`endif
                    end else begin
                        c_bits_d = c_bits_q + 1'b1;
                        tx_d     = shift_d[0];
                    end
                end else begin
                    c_clocks_d = c_clocks_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    c_clocks_d = '0;
                    state_d    = END;
                    tx_d       = 1'b1;
                end else begin
                    c_clocks_d = c_clocks_q + 1'b1;
                end
            end
`endif
            END: begin
                if (bit_end) begin
                    c_clocks_d = '0;
                    if (c_words_q == WORD_LAST) begin
                        c_words_d = '0;
                        state_d   = IDLE;
                        tx_d      = 1'b1;
                        s_ready_d = 1'b1;
                    end else begin
                        c_words_d = c_words_q + 1'b1;
                        state_d   = START;
                        tx_d      = 1'b0;
                    end
                end else begin
                    c_clocks_d = c_clocks_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any word in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            s_ready_q  <= 1'b0;
            c_clocks_q <= '0;
            c_bits_q   <= '0;
            c_words_q  <= '0;
            shift_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            s_ready_q  <= s_ready_d;
            c_clocks_q <= c_clocks_d;
            c_bits_q   <= c_bits_d;
            c_words_q  <= c_words_d;
            shift_q    <= shift_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign s_ready = s_ready_q;
    assign tx      = tx_q;

endmodule
